poly_unload: RTL and testbench

POLY_UNLOAD -- requirements
Module: poly_unload

---
 rtl/poly_unload_pkg.sv | 15 +
 rtl/poly_unload_if.sv | 30 +++
 rtl/poly_unload_fifo2.sv | 50 +++++
 rtl/poly_unload.sv | 114 +++++++++++
 tb/tb_poly_unload.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_unload_pkg.sv
// Shared constants and FSM encoding for the polynomial unload block.
package poly_unload_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int DATWID_DEF = 12;
  localparam int ADDWID_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/poly_unload_if.sv
// Control, NTT RAM read port and output stream of poly_unload; master = unload block side.
interface poly_unload_if
  import poly_unload_pkg::*;
#(
  parameter int DATWID = DATWID_DEF,
  parameter int ADDWID = ADDWID_DEF
);

  logic              start;
  logic              busy;
  logic              done;
  logic [ADDWID-1:0] ram_ra;
  logic              ram_re;
  logic [DATWID-1:0] ram_rdo;
  logic [DATWID-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  start, ram_rdo, m_ready,
    output busy, done, ram_ra, ram_re, m_data, m_valid, m_last
  );

  modport slave (
    output start, ram_rdo, m_ready,
    input  busy, done, ram_ra, ram_re, m_data, m_valid, m_last
  );

endinterface

// File: rtl/poly_unload_fifo2.sv
// Two-entry FIFO holding coefficient + last flag; push and pop in the same cycle are legal even when full.
module poly_unload_fifo2
  import poly_unload_pkg::*;
#(
  parameter int WID = DATWID_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [WID-1:0] push_data,
  input  logic           push_last,
  input  logic           pop,
  output logic           valid,
  output logic [WID-1:0] head_data,
  output logic           head_last,
  output logic [1:0]     count
);

  logic [WID-1:0] mem_data [2];
  logic [1:0]     mem_last;
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // When full, wr_ptr == rd_ptr: a simultaneous push overwrites the entry being popped this edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_last[wr_ptr] <= push_last;
    end
  end

  assign valid     = (cnt_q != 2'd0);
  assign head_data = mem_data[rd_ptr];
  assign head_last = mem_last[rd_ptr];
  assign count     = cnt_q;

endmodule

// File: rtl/poly_unload.sv
// Streams one polynomial (2**ADDWID words) from the NTT RAM to a ready/valid sink via a 2-deep FIFO.
// Optional POLY_UNLOAD_REDUCE_EN: conditional subtraction of KYBER_Q before the FIFO.
module poly_unload
  import poly_unload_pkg::*;
#(
  parameter int DATWID = DATWID_DEF,
  parameter int ADDWID = ADDWID_DEF
) (
  input  logic          clk,
  input  logic          rst,
  poly_unload_if.master bus
);

  localparam logic [ADDWID-1:0] LAST_ADDR = '1;
`ifdef POLY_UNLOAD_REDUCE_EN
  localparam logic [DATWID-1:0] Q_W = DATWID'(KYBER_Q);
`endif

  function automatic logic [DATWID-1:0] reduce_q(input logic [DATWID-1:0] v);
`ifdef POLY_UNLOAD_REDUCE_EN
    return (v >= Q_W) ? (v - Q_W) : v;
`else
    return v;
`endif
  endfunction

  state_t            state, state_nxt;
  logic [ADDWID-1:0] rd_addr;
  logic [ADDWID-1:0] ra_hold;
  logic              rd_vld_p1;
  logic              rd_last_p1;
  logic              issue;
  logic              pop;
  logic [2:0]        occ_sum;
  logic [2:0]        credit_lim;
  logic [1:0]        fifo_cnt;
  logic              fifo_valid;
  logic [DATWID-1:0] head_data;
  logic              head_last;

  // A word leaving the FIFO this cycle frees a slot, which keeps the stream gap-free at full rate.
  assign pop        = fifo_valid & bus.m_ready;
  assign occ_sum    = {1'b0, fifo_cnt} + {2'b00, rd_vld_p1};
  assign credit_lim = 3'd2 + {2'b00, pop};
  assign issue      = (state == ST_READ) && (occ_sum < credit_lim);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_READ;
      ST_READ:  if (issue && (rd_addr == LAST_ADDR)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && head_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.ram_re = issue;
    bus.ram_ra = issue ? rd_addr : ra_hold;
    case (state)
      ST_READ, ST_DRAIN: bus.busy = 1'b1;
      ST_DONE:           bus.done = 1'b1;
      default: ;
    endcase
  end

  // Stage p0 -> p1: read issued, RAM data returns one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr    <= '0;
      ra_hold    <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= issue;
      rd_last_p1 <= issue && (rd_addr == LAST_ADDR);
      if ((state == ST_IDLE) && bus.start) begin
        rd_addr <= '0;
      end else if (issue) begin
        ra_hold <= rd_addr;
        if (rd_addr != LAST_ADDR) rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  // Stage p1 -> FIFO: returned word (optionally reduced) captured alongside its last flag.
  poly_unload_fifo2 #(
    .WID (DATWID)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_vld_p1),
    .push_data (reduce_q(bus.ram_rdo)),
    .push_last (rd_last_p1),
    .pop       (pop),
    .valid     (fifo_valid),
    .head_data (head_data),
    .head_last (head_last),
    .count     (fifo_cnt)
  );

  assign bus.m_valid = fifo_valid;
  assign bus.m_data  = fifo_valid ? head_data : '0;
  assign bus.m_last  = fifo_valid & head_last;

endmodule

// File: tb/tb_poly_unload.sv
// Self-checking bench for poly_unload: RAM model, scoreboard of expected words, scenario tasks.
module tb_poly_unload;

  typedef struct packed {
    logic [11:0] data;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;

  poly_unload_if #(.DATWID(12), .ADDWID(7)) bus ();

  poly_unload #(.DATWID(12), .ADDWID(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [11:0] mem [128];
  logic [11:0] got [128];
  exp_t        exp_q [$];

  int total, bad;
  int cyc;
  int exp_addr, reads_issued, words_seen, dones_seen, outstanding;
  int first_tick, last_tick, done_tick;
  logic        prev_stall;
  logic [11:0] prev_data;
  logic        prev_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.ram_re) bus.ram_rdo <= mem[bus.ram_ra];
  end

  function automatic logic [11:0] model_reduce(input logic [11:0] v);
`ifdef POLY_UNLOAD_REDUCE_EN
    if (v >= 12'd3329) return v - 12'd3329;
`endif
    return v;
  endfunction

  task automatic load_ramp();
    for (int i = 0; i < 128; i++) mem[i] = 12'(i);
  endtask

  task automatic begin_run();
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 128; i++) begin
      e.data = model_reduce(mem[i]);
      e.last = (i == 127);
      exp_q.push_back(e);
    end
    exp_addr = 0; reads_issued = 0; words_seen = 0; dones_seen = 0; outstanding = 0;
    first_tick = -1; last_tick = -1; done_tick = -1; prev_stall = 1'b0;
  endtask

  // One clock: drive inputs after the falling edge, then sample and score the cycle.
  task automatic tick(input logic nxt_start, input logic nxt_ready);
    exp_t e;
    @(negedge clk);
    bus.start   = nxt_start;
    bus.m_ready = nxt_ready;
    #1;
    cyc++;
    if (bus.ram_re === 1'b1) begin
      total++;
      if (bus.ram_ra !== exp_addr[6:0] || exp_addr > 127) begin
        bad++;
        $display("FAIL ram_ra: got %0d want %0d (read #%0d)", bus.ram_ra, exp_addr, exp_addr);
      end
      exp_addr++; reads_issued++; outstanding++;
    end
    if (prev_stall) begin
      total++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last) begin
        bad++;
        $display("FAIL stall_stable: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                 bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
      end
    end
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_word: got d=%0d want no word", bus.m_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.m_data !== e.data || bus.m_last !== e.last) begin
          bad++;
          $display("FAIL word%0d: got d=%0d l=%b want d=%0d l=%b",
                   words_seen, bus.m_data, bus.m_last, e.data, e.last);
        end
      end
      if (words_seen < 128) got[words_seen] = bus.m_data;
      words_seen++; outstanding--;
      if (first_tick < 0) first_tick = cyc;
      last_tick = cyc;
    end
    total++;
    if (outstanding > 2) begin
      bad++;
      $display("FAIL outstanding: got %0d want <=2", outstanding);
    end
    if (bus.done === 1'b1) begin
      dones_seen++;
      done_tick = cyc;
    end
    prev_stall = bus.m_valid & ~bus.m_ready;
    prev_data  = bus.m_data;
    prev_last  = bus.m_last;
  endtask

  // mode 0: m_ready held 1; mode 1: m_ready toggles every cycle.
  task automatic run_to_done(input int mode, input int budget);
    int   d0;
    bit   ok;
    logic rdy;
    d0 = dones_seen; ok = 1'b0; rdy = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (mode == 1) rdy = ~rdy;
      tick(1'b0, rdy);
      if (dones_seen != d0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL run_timeout: got dones=%0d want %0d within %0d cycles", dones_seen, d0 + 1, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    total++;
    if ({bus.busy, bus.done, bus.ram_re, bus.m_valid, bus.m_last} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {bus.busy, bus.done, bus.ram_re, bus.m_valid, bus.m_last});
    end
    total++;
    if (bus.ram_ra !== 7'd0 || bus.m_data !== 12'd0) begin
      bad++;
      $display("FAIL reset_data: got ra=%0d d=%0d want 0 0", bus.ram_ra, bus.m_data);
    end
    rst = 1'b0;
    tick(1'b0, 1'b1);
  endtask

  task automatic test_stream();
    int s;
    load_ramp(); begin_run();
    tick(1'b1, 1'b1); s = cyc;
    tick(1'b0, 1'b1);
    total++;
    if (bus.ram_re !== 1'b1 || bus.ram_ra !== 7'd0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL lat_read: got re=%b ra=%0d busy=%b want 1 0 1", bus.ram_re, bus.ram_ra, bus.busy);
    end
    tick(1'b0, 1'b1);
    total++;
    if (bus.m_valid !== 1'b0) begin
      bad++; $display("FAIL lat_gap: got m_valid=%b want 0", bus.m_valid);
    end
    tick(1'b0, 1'b1);
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 12'd0) begin
      bad++; $display("FAIL lat_first: got v=%b d=%0d want 1 0", bus.m_valid, bus.m_data);
    end
    run_to_done(0, 400);
    total++;
    if (first_tick != s + 3 || last_tick - first_tick != 127) begin
      bad++; $display("FAIL burst: got first=%0d span=%0d want %0d 127", first_tick, last_tick - first_tick, s + 3);
    end
    total++;
    if (done_tick != last_tick + 1 || dones_seen != 1) begin
      bad++; $display("FAIL done_timing: got tick=%0d n=%0d want %0d 1", done_tick, dones_seen, last_tick + 1);
    end
    total++;
    if (words_seen != 128 || reads_issued != 128 || exp_q.size() != 0) begin
      bad++; $display("FAIL stream_count: got w=%0d r=%0d left=%0d want 128 128 0", words_seen, reads_issued, exp_q.size());
    end
    tick(1'b0, 1'b1);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ram_ra !== 7'd127) begin
      bad++; $display("FAIL after_done: got done=%b busy=%b ra=%0d want 0 0 127", bus.done, bus.busy, bus.ram_ra);
    end
  endtask

  task automatic test_toggle();
    load_ramp(); begin_run();
    tick(1'b1, 1'b1);
    run_to_done(1, 600);
    total++;
    if (words_seen != 128 || reads_issued != 128 || exp_q.size() != 0 || dones_seen != 1) begin
      bad++;
      $display("FAIL toggle_count: got w=%0d r=%0d left=%0d done=%0d want 128 128 0 1",
               words_seen, reads_issued, exp_q.size(), dones_seen);
    end
  endtask

  task automatic test_stall();
    load_ramp(); begin_run();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
    total++;
    if (reads_issued != 2) begin
      bad++; $display("FAIL stall_reads: got %0d want 2", reads_issued);
    end
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 12'd0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL stall_head: got v=%b d=%0d busy=%b want 1 0 1", bus.m_valid, bus.m_data, bus.busy);
    end
    run_to_done(0, 400);
    total++;
    if (words_seen != 128 || exp_q.size() != 0 || dones_seen != 1) begin
      bad++; $display("FAIL stall_count: got w=%0d left=%0d done=%0d want 128 0 1", words_seen, exp_q.size(), dones_seen);
    end
  endtask

  task automatic test_reset_midrun();
    bit hit;
    load_ramp(); begin_run();
    hit = 1'b0;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, 1'b1);
      if (words_seen == 50) begin hit = 1'b1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL reach_word50: got %0d words want 50", words_seen); end
    rst = 1'b1;
    tick(1'b0, 1'b1);
    total++;
    if ({bus.busy, bus.done, bus.ram_re, bus.m_valid, bus.m_last} !== 5'b0 ||
        bus.ram_ra !== 7'd0 || bus.m_data !== 12'd0) begin
      bad++;
      $display("FAIL abort_outputs: got ctrl=%b ra=%0d d=%0d want 00000 0 0",
               {bus.busy, bus.done, bus.ram_re, bus.m_valid, bus.m_last}, bus.ram_ra, bus.m_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    total++;
    if (dones_seen != 0 || bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL abort_quiet: got done=%0d v=%b busy=%b want 0 0 0", dones_seen, bus.m_valid, bus.busy);
    end
    begin_run();
    tick(1'b1, 1'b1);
    run_to_done(0, 400);
    total++;
    if (words_seen != 128 || exp_q.size() != 0 || dones_seen != 1 || got[0] !== 12'd0) begin
      bad++; $display("FAIL restart_stream: got w=%0d left=%0d done=%0d first=%0d want 128 0 1 0",
                      words_seen, exp_q.size(), dones_seen, got[0]);
    end
  endtask

  task automatic test_start_while_busy();
    load_ramp(); begin_run();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    run_to_done(0, 400);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    total++;
    if (words_seen != 128 || reads_issued != 128 || dones_seen != 1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL busy_start: got w=%0d r=%0d done=%0d busy=%b want 128 128 1 0",
                      words_seen, reads_issued, dones_seen, bus.busy);
    end
  endtask

  task automatic test_reduce();
    logic [11:0] want0, want2;
`ifdef POLY_UNLOAD_REDUCE_EN
    want0 = 12'd1;    want2 = 12'd0;
`else
    want0 = 12'd3330; want2 = 12'd3329;
`endif
    load_ramp();
    mem[0] = 12'd3330; mem[1] = 12'd3328; mem[2] = 12'd3329; mem[3] = 12'd4095;
    begin_run();
    tick(1'b1, 1'b1);
    run_to_done(0, 400);
    total++;
    if (got[0] !== want0 || got[1] !== 12'd3328 || got[2] !== want2) begin
      bad++; $display("FAIL reduce: got %0d %0d %0d want %0d 3328 %0d", got[0], got[1], got[2], want0, want2);
    end
    total++;
    if (words_seen != 128 || exp_q.size() != 0) begin
      bad++; $display("FAIL reduce_count: got w=%0d left=%0d want 128 0", words_seen, exp_q.size());
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.m_ready = 1'b0;
    load_ramp();
    begin_run();
    test_reset();
    test_stream();
    test_toggle();
    test_stall();
    test_reset_midrun();
    test_start_while_busy();
    test_reduce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
